// File: rtl/rs_if.sv
// Dispatch, result-bus and issue signals of the reservation station.
// master = pipeline side, slave = station.
interface rs_if;
    localparam int InstrIdWidth = 6;
    localparam int ImmWidth     = 32;
    localparam int AddrWidth    = 32;
    localparam int ROBIdxWidth  = 5;
    localparam int WordWidth    = 32;

    logic                    disp_en_in;
    logic [InstrIdWidth-1:0] disp_instr_id_in;
    logic [ImmWidth-1:0]     disp_imm_in;
    logic [AddrWidth-1:0]    disp_pc_in;
    logic [ROBIdxWidth-1:0]  disp_rob_pos_in;
    logic                    disp_rs1_rdy_in;
    logic [WordWidth-1:0]    disp_rs1_val_in;
    logic [ROBIdxWidth-1:0]  disp_rs1_tag_in;
    logic                    disp_rs2_rdy_in;
    logic [WordWidth-1:0]    disp_rs2_val_in;
    logic [ROBIdxWidth-1:0]  disp_rs2_tag_in;
    logic                    full_out;

    logic                    ex_cdb_en_in;
    logic [ROBIdxWidth-1:0]  ex_cdb_rob_pos_in;
    logic [WordWidth-1:0]    ex_cdb_res_in;
    logic                    lsb_cdb_en_in;
    logic [ROBIdxWidth-1:0]  lsb_cdb_rob_pos_in;
    logic [WordWidth-1:0]    lsb_cdb_res_in;

    logic                    rs_to_ex_en_out;
    logic [InstrIdWidth-1:0] instr_id_out;
    logic [ImmWidth-1:0]     imm_out;
    logic [WordWidth-1:0]    rs1_out;
    logic [WordWidth-1:0]    rs2_out;
    logic [AddrWidth-1:0]    pc_out;
    logic [ROBIdxWidth-1:0]  rob_pos_out;

    modport master (
        output disp_en_in, disp_instr_id_in, disp_imm_in, disp_pc_in,
        output disp_rob_pos_in,
        output disp_rs1_rdy_in, disp_rs1_val_in, disp_rs1_tag_in,
        output disp_rs2_rdy_in, disp_rs2_val_in, disp_rs2_tag_in,
        output ex_cdb_en_in, ex_cdb_rob_pos_in, ex_cdb_res_in,
        output lsb_cdb_en_in, lsb_cdb_rob_pos_in, lsb_cdb_res_in,
        input  full_out, rs_to_ex_en_out, instr_id_out, imm_out,
        input  rs1_out, rs2_out, pc_out, rob_pos_out
    );

    modport slave (
        input  disp_en_in, disp_instr_id_in, disp_imm_in, disp_pc_in,
        input  disp_rob_pos_in,
        input  disp_rs1_rdy_in, disp_rs1_val_in, disp_rs1_tag_in,
        input  disp_rs2_rdy_in, disp_rs2_val_in, disp_rs2_tag_in,
        input  ex_cdb_en_in, ex_cdb_rob_pos_in, ex_cdb_res_in,
        input  lsb_cdb_en_in, lsb_cdb_rob_pos_in, lsb_cdb_res_in,
        output full_out, rs_to_ex_en_out, instr_id_out, imm_out,
        output rs1_out, rs2_out, pc_out, rob_pos_out
    );
endinterface

// File: rtl/rs.sv
// Integer reservation station: CDB wakeup, lowest-index select, registered issue.
// Define RS_WAKEUP_BYPASS_EN to let an entry issue in its wakeup cycle.
module rs #(
    parameter int RS_SIZE = 16
) (
    input logic clk_in,
    input logic rst_in,
    input logic rdy_in,
    input logic clr_in,
    rs_if.slave bus
);
    localparam int InstrIdWidth = 6;
    localparam int ImmWidth     = 32;
    localparam int AddrWidth    = 32;
    localparam int ROBIdxWidth  = 5;
    localparam int WordWidth    = 32;
    localparam int IdxWidth     = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]      valid;
    logic [InstrIdWidth-1:0] e_id     [RS_SIZE];
    logic [ImmWidth-1:0]     e_imm    [RS_SIZE];
    logic [AddrWidth-1:0]    e_pc     [RS_SIZE];
    logic [ROBIdxWidth-1:0]  e_rob    [RS_SIZE];
    logic [RS_SIZE-1:0]      e_r1_rdy;
    logic [WordWidth-1:0]    e_r1_val [RS_SIZE];
    logic [ROBIdxWidth-1:0]  e_r1_tag [RS_SIZE];
    logic [RS_SIZE-1:0]      e_r2_rdy;
    logic [WordWidth-1:0]    e_r2_val [RS_SIZE];
    logic [ROBIdxWidth-1:0]  e_r2_tag [RS_SIZE];

    logic [RS_SIZE-1:0]      hit1;
    logic [RS_SIZE-1:0]      hit2;
    logic [WordWidth-1:0]    cdb1     [RS_SIZE];
    logic [WordWidth-1:0]    cdb2     [RS_SIZE];
    logic [RS_SIZE-1:0]      eligible;

    logic                    d1_rdy;
    logic [WordWidth-1:0]    d1_val;
    logic                    d2_rdy;
    logic [WordWidth-1:0]    d2_val;

    logic                    sel_found;
    logic [IdxWidth-1:0]     sel_idx;
    logic [IdxWidth-1:0]     free_idx;
    logic [WordWidth-1:0]    sel_r1;
    logic [WordWidth-1:0]    sel_r2;
    logic                    full;

    logic                    iss_en;
    logic [InstrIdWidth-1:0] iss_id;
    logic [ImmWidth-1:0]     iss_imm;
    logic [WordWidth-1:0]    iss_r1;
    logic [WordWidth-1:0]    iss_r2;
    logic [AddrWidth-1:0]    iss_pc;
    logic [ROBIdxWidth-1:0]  iss_rob;

    assign full = &valid;

    // EX bus wins if both buses claim the same tag.
    always_comb begin
        logic ex_m1, ls_m1, ex_m2, ls_m2;
        hit1 = '0;
        hit2 = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ex_m1 = bus.ex_cdb_en_in && e_r1_tag[i] == bus.ex_cdb_rob_pos_in;
            ls_m1 = bus.lsb_cdb_en_in && e_r1_tag[i] == bus.lsb_cdb_rob_pos_in;
            ex_m2 = bus.ex_cdb_en_in && e_r2_tag[i] == bus.ex_cdb_rob_pos_in;
            ls_m2 = bus.lsb_cdb_en_in && e_r2_tag[i] == bus.lsb_cdb_rob_pos_in;
            hit1[i] = !e_r1_rdy[i] && (ex_m1 || ls_m1);
            hit2[i] = !e_r2_rdy[i] && (ex_m2 || ls_m2);
            cdb1[i] = ex_m1 ? bus.ex_cdb_res_in : bus.lsb_cdb_res_in;
            cdb2[i] = ex_m2 ? bus.ex_cdb_res_in : bus.lsb_cdb_res_in;
        end
    end

    always_comb begin
        logic ex_m, ls_m;
        ex_m = bus.ex_cdb_en_in &&
               bus.disp_rs1_tag_in == bus.ex_cdb_rob_pos_in;
        ls_m = bus.lsb_cdb_en_in &&
               bus.disp_rs1_tag_in == bus.lsb_cdb_rob_pos_in;
        d1_rdy = bus.disp_rs1_rdy_in || ex_m || ls_m;
        d1_val = bus.disp_rs1_rdy_in ? bus.disp_rs1_val_in :
                 ex_m ? bus.ex_cdb_res_in : bus.lsb_cdb_res_in;
        ex_m = bus.ex_cdb_en_in &&
               bus.disp_rs2_tag_in == bus.ex_cdb_rob_pos_in;
        ls_m = bus.lsb_cdb_en_in &&
               bus.disp_rs2_tag_in == bus.lsb_cdb_rob_pos_in;
        d2_rdy = bus.disp_rs2_rdy_in || ex_m || ls_m;
        d2_val = bus.disp_rs2_rdy_in ? bus.disp_rs2_val_in :
                 ex_m ? bus.ex_cdb_res_in : bus.lsb_cdb_res_in;
    end

    always_comb begin
        eligible  = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            eligible[i] = valid[i] && (e_r1_rdy[i] || hit1[i]) &&
                          (e_r2_rdy[i] || hit2[i]);
`else
            eligible[i] = valid[i] && e_r1_rdy[i] && e_r2_rdy[i];
`endif
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_found = 1'b1;
                sel_idx   = IdxWidth'(i);
            end
            if (!valid[i])
                free_idx = IdxWidth'(i);
        end
`ifdef RS_WAKEUP_BYPASS_EN
        sel_r1 = e_r1_rdy[sel_idx] ? e_r1_val[sel_idx] : cdb1[sel_idx];
        sel_r2 = e_r2_rdy[sel_idx] ? e_r2_val[sel_idx] : cdb2[sel_idx];
`else
        sel_r1 = e_r1_val[sel_idx];
        sel_r2 = e_r2_val[sel_idx];
`endif
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid    <= '0;
            e_r1_rdy <= '0;
            e_r2_rdy <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                e_id[i]     <= '0;
                e_imm[i]    <= '0;
                e_pc[i]     <= '0;
                e_rob[i]    <= '0;
                e_r1_val[i] <= '0;
                e_r1_tag[i] <= '0;
                e_r2_val[i] <= '0;
                e_r2_tag[i] <= '0;
            end
            iss_en  <= 1'b0;
            iss_id  <= '0;
            iss_imm <= '0;
            iss_r1  <= '0;
            iss_r2  <= '0;
            iss_pc  <= '0;
            iss_rob <= '0;
        end else if (clr_in) begin
            valid  <= '0;
            iss_en <= 1'b0;
        end else if (!rdy_in) begin
            iss_en <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid[i] && hit1[i]) begin
                    e_r1_rdy[i] <= 1'b1;
                    e_r1_val[i] <= cdb1[i];
                end
                if (valid[i] && hit2[i]) begin
                    e_r2_rdy[i] <= 1'b1;
                    e_r2_val[i] <= cdb2[i];
                end
            end
            iss_en <= sel_found;
            if (sel_found) begin
                valid[sel_idx] <= 1'b0;
                iss_id  <= e_id[sel_idx];
                iss_imm <= e_imm[sel_idx];
                iss_r1  <= sel_r1;
                iss_r2  <= sel_r2;
                iss_pc  <= e_pc[sel_idx];
                iss_rob <= e_rob[sel_idx];
            end
            // The free slot is invalid, so it never collides with issue/wakeup.
            if (bus.disp_en_in && !full) begin
                valid[free_idx]    <= 1'b1;
                e_id[free_idx]     <= bus.disp_instr_id_in;
                e_imm[free_idx]    <= bus.disp_imm_in;
                e_pc[free_idx]     <= bus.disp_pc_in;
                e_rob[free_idx]    <= bus.disp_rob_pos_in;
                e_r1_rdy[free_idx] <= d1_rdy;
                e_r1_val[free_idx] <= d1_val;
                e_r1_tag[free_idx] <= bus.disp_rs1_tag_in;
                e_r2_rdy[free_idx] <= d2_rdy;
                e_r2_val[free_idx] <= d2_val;
                e_r2_tag[free_idx] <= bus.disp_rs2_tag_in;
            end
        end
    end

    assign bus.full_out        = full;
    assign bus.rs_to_ex_en_out = iss_en;
    assign bus.instr_id_out    = iss_id;
    assign bus.imm_out         = iss_imm;
    assign bus.rs1_out         = iss_r1;
    assign bus.rs2_out         = iss_r2;
    assign bus.pc_out          = iss_pc;
    assign bus.rob_pos_out     = iss_rob;
endmodule

// File: tb/tb_rs.sv
// Scoreboard bench for the reservation station: expected issues are queued
// at stimulus time and popped whenever the station issues.
module tb_rs;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clr;

    always #5 clk = ~clk;

    rs_if bus ();

    rs #(.RS_SIZE(16)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .clr_in (clr),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0]  rob;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [5:0]  id;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] rob, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [5:0] id);
        exp_t e;
        e.rob = rob; e.rs1 = rs1; e.rs2 = rs2;
        e.imm = imm; e.pc = pc; e.id = id;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.rs_to_ex_en_out) begin
            if (sb.size() == 0) begin
                chk("spurious_issue", 64'(bus.rob_pos_out), 64'h1f00);
            end else begin
                e = sb.pop_front();
                chk("iss_rob", 64'(bus.rob_pos_out), 64'(e.rob));
                chk("iss_rs1", 64'(bus.rs1_out), 64'(e.rs1));
                chk("iss_rs2", 64'(bus.rs2_out), 64'(e.rs2));
                chk("iss_imm", 64'(bus.imm_out), 64'(e.imm));
                chk("iss_pc", 64'(bus.pc_out), 64'(e.pc));
                chk("iss_id", 64'(bus.instr_id_out), 64'(e.id));
            end
        end
    endtask

    task automatic disp(input logic [5:0] id, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rob,
                        input logic r1r, input logic [31:0] r1v,
                        input logic [4:0] r1t, input logic r2r,
                        input logic [31:0] r2v, input logic [4:0] r2t);
        bus.disp_en_in       = 1'b1;
        bus.disp_instr_id_in = id;
        bus.disp_imm_in      = imm;
        bus.disp_pc_in       = pc;
        bus.disp_rob_pos_in  = rob;
        bus.disp_rs1_rdy_in  = r1r;
        bus.disp_rs1_val_in  = r1v;
        bus.disp_rs1_tag_in  = r1t;
        bus.disp_rs2_rdy_in  = r2r;
        bus.disp_rs2_val_in  = r2v;
        bus.disp_rs2_tag_in  = r2t;
    endtask

    task automatic ex_cdb(input logic [4:0] pos, input logic [31:0] res);
        bus.ex_cdb_en_in      = 1'b1;
        bus.ex_cdb_rob_pos_in = pos;
        bus.ex_cdb_res_in     = res;
    endtask

    task automatic idle();
        bus.disp_en_in    = 1'b0;
        bus.ex_cdb_en_in  = 1'b0;
        bus.lsb_cdb_en_in = 1'b0;
    endtask

    task automatic en_is(input string tag, input logic exp);
        chk(tag, 64'(bus.rs_to_ex_en_out), 64'(exp));
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        clr = 1'b0;
        disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        bus.ex_cdb_rob_pos_in  = '0;
        bus.ex_cdb_res_in      = '0;
        bus.lsb_cdb_rob_pos_in = '0;
        bus.lsb_cdb_res_in     = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_en", 64'(bus.rs_to_ex_en_out), 0);
        chk("rst_full", 64'(bus.full_out), 0);
        chk("rst_rs1", 64'(bus.rs1_out), 0);
        chk("rst_rob", 64'(bus.rob_pos_out), 0);
        chk("rst_pc", 64'(bus.pc_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Both operands ready: issue one edge after dispatch.
        disp(1, 0, 32'h1000, 3, 1, 5, 0, 1, 7, 0);
        push(3, 5, 7, 0, 32'h1000, 1);
        tick();
        idle();
        en_is("t1_latency", 0);
        tick();
        en_is("t1_issue", 1);
        tick();
        en_is("t1_done", 0);

        // rs1 waits on tag 9, woken by EX.
        disp(2, 32'h10, 32'h1004, 4, 0, 0, 9, 1, 0, 0);
        tick();
        idle();
        en_is("t2_wait0", 0);
        tick();
        en_is("t2_wait1", 0);
        ex_cdb(9, 32'h100);
        push(4, 32'h100, 0, 32'h10, 32'h1004, 2);
        tick();
        idle();
`ifdef RS_WAKEUP_BYPASS_EN
        en_is("t2_cdb_edge", 1);
`else
        en_is("t2_cdb_edge", 0);
        tick();
        en_is("t2_after", 1);
`endif
        tick();
        en_is("t2_done", 0);

        // Dispatch-cycle bypass from the load bus.
        disp(3, 0, 32'h1008, 5, 1, 32'h22, 0, 0, 0, 12);
        bus.lsb_cdb_en_in      = 1'b1;
        bus.lsb_cdb_rob_pos_in = 12;
        bus.lsb_cdb_res_in     = 32'habc;
        push(5, 32'h22, 32'habc, 0, 32'h1008, 3);
        tick();
        idle();
        en_is("t3_latency", 0);
        tick();
        en_is("t3_issue", 1);
        tick();

        // Fill every entry, drop one more, then free entry 0.
        for (int i = 0; i < 16; i++) begin
            disp(4, 32'(i), 32'h2000 + 32'(4 * i), 5'(i),
                 0, 0, 5'(16 + i), 1, 32'(i), 0);
            tick();
            if (i == 14)
                chk("t4_not_full", 64'(bus.full_out), 0);
        end
        idle();
        chk("t4_full", 64'(bus.full_out), 1);
        disp(5, 0, 32'h3000, 20, 1, 1, 0, 1, 2, 0);
        tick();
        idle();
        chk("t4_full_hold", 64'(bus.full_out), 1);
        en_is("t4_no_issue", 0);
        ex_cdb(16, 32'h55);
        push(0, 32'h55, 0, 0, 32'h2000, 4);
        tick();
        idle();
`ifdef RS_WAKEUP_BYPASS_EN
        en_is("t4_issue", 1);
        chk("t4_full_fall", 64'(bus.full_out), 0);
`else
        en_is("t4_capture", 0);
        chk("t4_full_cap", 64'(bus.full_out), 1);
        tick();
        en_is("t4_issue", 1);
        chk("t4_full_fall", 64'(bus.full_out), 0);
`endif
        tick();
        en_is("t4_quiet", 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_flush_full", 64'(bus.full_out), 0);

        // Four entries ready, then flush.
        for (int i = 0; i < 4; i++) begin
            disp(6, 0, 32'h4000, 5'(10 + i), 0, 0, 8, 1, 32'(i), 0);
            tick();
        end
        idle();
        ex_cdb(8, 32'h88);
`ifdef RS_WAKEUP_BYPASS_EN
        push(10, 32'h88, 0, 0, 32'h4000, 6);
`endif
        tick();
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en_is("t5_clr_en", 0);
        chk("t5_clr_full", 64'(bus.full_out), 0);
        tick();
        en_is("t5_flushed", 0);
        for (int i = 0; i < 16; i++) begin
            disp(7, 0, 32'h5000, 5'(i), 0, 0, 30, 0, 0, 30);
            tick();
            if (i == 14)
                chk("t5_refill_15", 64'(bus.full_out), 0);
        end
        idle();
        chk("t5_refill_16", 64'(bus.full_out), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Stall with ready entries; ignored inputs must not leak in.
        for (int i = 0; i < 3; i++) begin
            disp(8, 0, 32'h6000, 5'(20 + i), 0, 0, 8, 1, 32'h100 + 32'(i), 0);
            tick();
        end
        idle();
        ex_cdb(8, 32'h77);
`ifdef RS_WAKEUP_BYPASS_EN
        push(20, 32'h77, 32'h100, 0, 32'h6000, 8);
`endif
        tick();
        idle();
        rdy = 1'b0;
        disp(9, 0, 32'h7000, 1, 1, 1, 0, 1, 1, 0);
        bus.lsb_cdb_en_in      = 1'b1;
        bus.lsb_cdb_rob_pos_in = 8;
        bus.lsb_cdb_res_in     = 32'hdead;
        for (int i = 0; i < 3; i++) begin
            tick();
            en_is("t6_stall", 0);
        end
        idle();
        rdy = 1'b1;
`ifndef RS_WAKEUP_BYPASS_EN
        push(20, 32'h77, 32'h100, 0, 32'h6000, 8);
`endif
        push(21, 32'h77, 32'h101, 0, 32'h6000, 8);
        push(22, 32'h77, 32'h102, 0, 32'h6000, 8);
        tick();
        en_is("t6_resume", 1);
        tick();
        en_is("t6_next", 1);
`ifndef RS_WAKEUP_BYPASS_EN
        tick();
        en_is("t6_last", 1);
`endif
        tick();
        en_is("t6_empty", 0);

        chk("sb_drain", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/rs.md
# rs

Reservation station for the out-of-order integer pipeline. The dispatcher writes decoded ALU and branch instructions into the station along with their operands or ROB tags. The station snoops the EX and LSB result buses to wake up waiting operands. Each cycle it selects at most one fully ready entry and drives it through registered outputs to the execute unit, which computes the result, branch decision and target combinationally.

## Interface
- `RS_SIZE`, default 16: number of entries; a power of two, at least 2.
- `clk_in` in 1: clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `rdy_in` in 1: global ready; while it is low the station holds its state.
- `clr_in` in 1: ROB mispredict flush.
- `disp_en_in` in 1: dispatch strobe.
- `disp_instr_id_in` in `InstrIdWidth`: instruction ID.
- `disp_imm_in` in `ImmWidth`: immediate.
- `disp_pc_in` in `AddrWidth`: PC of the instruction.
- `disp_rob_pos_in` in `ROBIdxWidth`: destination ROB index.
- `disp_rs1_rdy_in` in 1, `disp_rs1_val_in` in `WordWidth`, `disp_rs1_tag_in` in `ROBIdxWidth`: operand 1. When `rdy` is 1 the value is valid; otherwise the tag names the producer.
- `disp_rs2_rdy_in`, `disp_rs2_val_in`, `disp_rs2_tag_in`: operand 2, same encoding.
- `full_out` out 1: no free entry.
- `ex_cdb_en_in` in 1, `ex_cdb_rob_pos_in` in `ROBIdxWidth`, `ex_cdb_res_in` in `WordWidth`: EX result broadcast.
- `lsb_cdb_en_in` in 1, `lsb_cdb_rob_pos_in` in `ROBIdxWidth`, `lsb_cdb_res_in` in `WordWidth`: load result broadcast.
- `rs_to_ex_en_out` out 1: issue valid.
- `instr_id_out`, `imm_out`, `rs1_out`, `rs2_out`, `pc_out`, `rob_pos_out` out: issued fields, same widths as the dispatch fields. All are registered.

## Operation
- Each entry holds: valid, instr_id, imm, pc, rob_pos, and for each operand: rdy, val, tag.
- **Allocation:** on `disp_en_in`, the lowest-index invalid entry is written.
  - `full_out` = all entries valid. It is computed from registered state only; an issue in the same cycle does not clear it.
  - Dispatch while `full_out` = 1 is a protocol violation. The dispatch is dropped and no entry is overwritten.
- **Dispatch bypass:** if a dispatched operand is not ready and its tag equals an active CDB `rob_pos` in the same cycle, the entry stores the CDB value with rdy = 1.
- **Wakeup:** every valid entry operand with rdy = 0 whose tag matches an active CDB captures that CDB's result and sets rdy = 1.
  - If both CDBs match (illegal; ROB tags are unique), the EX bus wins.
- **Select:** the lowest-index valid entry with both operands ready, evaluated on registered state, is issued.
  - Its fields load into the output registers, `rs_to_ex_en_out` goes to 1, and the entry is invalidated on the same edge.
  - If no entry is ready, `rs_to_ex_en_out` goes to 0; the other outputs hold their previous values.
- **Flush:** `clr_in` invalidates all entries and clears `rs_to_ex_en_out` on the next edge. It takes priority over dispatch, wakeup and issue in that cycle.
- **Stall:** when `rdy_in` is low (and `clr_in` is low), entries are frozen, dispatch and CDB inputs are ignored, and `rs_to_ex_en_out` is loaded with 0 so EX never executes an entry twice.

## Timing
- **Reset:** all entries invalid; `full_out` = 0; `rs_to_ex_en_out` = 0; all issued fields = 0. Reset takes effect immediately (asynchronous) and may interrupt any operation.
- **Dispatch to issue:** minimum 1 cycle. An entry dispatched with both operands ready at edge N appears on the outputs after edge N+1.
- **Wakeup to issue:**
  - Without bypass: an operand captured at edge N makes the entry eligible in the cycle after N, so it is issued at edge N+1.
  - With bypass: see Configuration.
- Dispatch into an entry and issue of a different entry may occur on the same edge.
- Throughput: one issue per cycle.

## Configuration
- `RS_WAKEUP_BYPASS_EN` defined: an already-valid entry whose last missing operand matches an active CDB in the current cycle is eligible for select in that same cycle.
  - The issued operand is taken directly from the CDB value.
  - The entry is still invalidated on that edge.
  - Freshly dispatched entries are never eligible in their dispatch cycle.
- Not defined: select considers registered rdy bits only, which adds one cycle of wakeup-to-issue latency.

## Test plan
- Dispatch ADD with rs1 = 5 and rs2 = 7, both ready, rob_pos = 3 → one cycle later `rs_to_ex_en_out` = 1, `rs1_out` = 5, `rs2_out` = 7, `rob_pos_out` = 3; the following cycle `rs_to_ex_en_out` = 0.
- Dispatch ADDI with rs1 waiting on tag 9, then `ex_cdb_en_in` with rob_pos 9 and res 0x100 → issue with `rs1_out` = 0x100.
  - With the macro, issue happens at the CDB edge.
  - Without the macro, issue happens one edge later.
- Dispatch in the same cycle as an `lsb_cdb` match on its rs2 tag → the entry stores the value and issues on the next cycle with the captured `rs2_out`.
- Fill all `RS_SIZE` entries with unready operands → `full_out` = 1. An extra dispatch is dropped. A broadcast on entry 0's tag issues entry 0, and `full_out` falls on the following cycle.
- With 4 entries ready, assert `clr_in` → no issue on the next cycle, `full_out` = 0, and subsequent dispatches allocate from entry 0.
- Hold `rdy_in` low for 3 cycles with ready entries present → `rs_to_ex_en_out` = 0 throughout. Issue resumes one cycle after `rdy_in` rises.
